// File: rtl/flex_pkg.sv
// Shared types for the tile scheduler: FSM states, error codes and the
// default watchdog limit.
package flex_pkg;

    localparam int WDOG_CYC_DEF = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPATCH,
        S_COMPUTE,
        S_COLLECT,
        S_NEXT,
        S_FINISH,
        S_ERROR
    } sched_state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ARRAY = 2'd1,
        ERR_ZERO  = 2'd2,
        ERR_WDOG  = 2'd3
    } err_code_t;

endpackage

// File: rtl/sys_tile_sched_wdog.sv
// Per-phase watchdog for sys_tile_sched; only instantiated when
// SYS_SCHED_WDOG_EN is defined.
module sched_wdog
    import flex_pkg::*;
#(
    parameter int LIMIT = WDOG_CYC_DEF
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_lim;

    // cnt_q holds the number of completed cycles, so the LIMIT-th enabled
    // cycle is the one that flags expiry.
    assign at_lim  = (cnt_q == CW'(LIMIT - 1));
    assign expired = en && at_lim;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !at_lim) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sys_tile_sched.sv
// Tile job scheduler: sequences dispatch, compute and collect per tile.
// Optional per-phase watchdog enabled by defining SYS_SCHED_WDOG_EN.
module sys_tile_sched
    import flex_pkg::*;
#(
    parameter int TILE_W   = 8,
    parameter int WDOG_CYC = WDOG_CYC_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [TILE_W-1:0] cfg_tiles,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [TILE_W-1:0] tile_idx,
    output logic              disp_start,
    input  logic              disp_done,
    input  logic              sa_done,
    input  logic              sa_err,
    output logic              col_start,
    input  logic              col_done,
    output logic              tile_clr
);

    sched_state_t      state_q, state_d;
    err_code_t         err_code_q, err_code_d;
    logic [TILE_W-1:0] tiles_q, tiles_d;
    logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              disp_start_q, disp_start_d;
    logic              col_start_q, col_start_d;
    logic              tile_clr_q, tile_clr_d;
    logic              sa_seen_q, sa_seen_d;
    logic              in_phase;
    logic              wdog_exp;

    assign in_phase = (state_q == S_DISPATCH) || (state_q == S_COMPUTE) ||
                      (state_q == S_COLLECT);

`ifdef SYS_SCHED_WDOG_EN
    sched_wdog #(.LIMIT(WDOG_CYC)) u_wdog (
        .clk     (clk),
        .nrst    (nrst),
        .clr     (state_d != state_q),
        .en      (in_phase),
        .expired (wdog_exp)
    );
`else
    // Watchdog compiled out: constant false, only keeps WDOG_CYC referenced.
    assign wdog_exp = (WDOG_CYC < 1) && (WDOG_CYC > 1);
`endif

    always_comb begin
        state_d      = state_q;
        tiles_d      = tiles_q;
        tile_idx_d   = tile_idx_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        sa_seen_d    = sa_seen_q;
        busy_d       = 1'b1;
        done_d       = 1'b0;
        disp_start_d = 1'b0;
        col_start_d  = 1'b0;
        tile_clr_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    if (cfg_tiles != '0) begin
                        state_d      = S_DISPATCH;
                        tiles_d      = cfg_tiles;
                        tile_idx_d   = '0;
                        err_d        = 1'b0;
                        err_code_d   = ERR_NONE;
                        sa_seen_d    = 1'b0;
                        disp_start_d = 1'b1;
                    end else begin
                        state_d    = S_ERROR;
                        err_d      = 1'b1;
                        err_code_d = ERR_ZERO;
                    end
                end
            end
            S_DISPATCH: begin
                // An early sa_done is remembered so COMPUTE can pass straight through.
                sa_seen_d = sa_seen_q | sa_done;
                if (disp_done) begin
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (sa_done || sa_seen_q) begin
                    state_d     = S_COLLECT;
                    col_start_d = 1'b1;
                    sa_seen_d   = 1'b0;
                end
            end
            S_COLLECT: begin
                col_start_d = 1'b1;
                if (col_done) begin
                    state_d     = S_NEXT;
                    col_start_d = 1'b0;
                    tile_clr_d  = 1'b1;
                end
            end
            S_NEXT: begin
                if (tile_idx_q == tiles_q - TILE_W'(1)) begin
                    state_d = S_FINISH;
                end else begin
                    state_d      = S_DISPATCH;
                    tile_idx_d   = tile_idx_q + TILE_W'(1);
                    disp_start_d = 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            S_ERROR: begin
                state_d    = S_IDLE;
                busy_d     = 1'b0;
                tile_clr_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Array error anywhere in the tile loop overrides the normal transition.
        if (sa_err && (in_phase || state_q == S_NEXT)) begin
            state_d      = S_ERROR;
            err_d        = 1'b1;
            err_code_d   = ERR_ARRAY;
            sa_seen_d    = 1'b0;
            disp_start_d = 1'b0;
            col_start_d  = 1'b0;
            tile_clr_d   = 1'b0;
        end else if (wdog_exp) begin
            state_d      = S_ERROR;
            err_d        = 1'b1;
            err_code_d   = ERR_WDOG;
            sa_seen_d    = 1'b0;
            disp_start_d = 1'b0;
            col_start_d  = 1'b0;
            tile_clr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            tiles_q      <= '0;
            tile_idx_q   <= '0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            sa_seen_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            disp_start_q <= 1'b0;
            col_start_q  <= 1'b0;
            tile_clr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tiles_q      <= tiles_d;
            tile_idx_q   <= tile_idx_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            sa_seen_q    <= sa_seen_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            disp_start_q <= disp_start_d;
            col_start_q  <= col_start_d;
            tile_clr_q   <= tile_clr_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign tile_idx   = tile_idx_q;
    assign disp_start = disp_start_q;
    assign col_start  = col_start_q;
    assign tile_clr   = tile_clr_q;

endmodule

// File: tb/tb_sys_tile_sched.sv
// Directed self-checking bench for sys_tile_sched (watchdog case follows
// SYS_SCHED_WDOG_EN).
module tb_sys_tile_sched;

    localparam int TILE_W = 8;

    logic              clk;
    logic              nrst;
    logic              start;
    logic [TILE_W-1:0] cfg_tiles;
    logic              busy, done, err;
    logic [1:0]        err_code;
    logic [TILE_W-1:0] tile_idx;
    logic              disp_start, disp_done, sa_done, sa_err;
    logic              col_start, col_done, tile_clr;

    int checks   = 0;
    int failures = 0;

    int n_disp = 0, n_clr = 0, n_done = 0, n_col = 0, n_consec = 0;
    logic p_ds = 1'b0, p_tc = 1'b0, p_dn = 1'b0;
    int idx_log[$];

    sys_tile_sched #(.TILE_W(TILE_W), .WDOG_CYC(16)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .cfg_tiles  (cfg_tiles),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .tile_idx   (tile_idx),
        .disp_start (disp_start),
        .disp_done  (disp_done),
        .sa_done    (sa_done),
        .sa_err     (sa_err),
        .col_start  (col_start),
        .col_done   (col_done),
        .tile_clr   (tile_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and back-to-back detection, sampling settled values.
    always @(posedge clk) begin
        if (disp_start) begin
            n_disp <= n_disp + 1;
            idx_log.push_back(int'(tile_idx));
        end
        if (tile_clr)  n_clr  <= n_clr + 1;
        if (done)      n_done <= n_done + 1;
        if (col_start) n_col  <= n_col + 1;
        if ((disp_start && p_ds) || (tile_clr && p_tc) || (done && p_dn))
            n_consec <= n_consec + 1;
        p_ds <= disp_start;
        p_tc <= tile_clr;
        p_dn <= done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // sel: 0 disp_start, 1 col_start, 2 done
    task automatic wait_out(input int sel, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 64 && !hit; i++) begin
            case (sel)
                0:       hit = disp_start;
                1:       hit = col_start;
                default: hit = done;
            endcase
            if (!hit) @(negedge clk);
        end
        chk(tag, 32'(hit), 1);
    endtask

    task automatic do_start(input logic [TILE_W-1:0] n);
        start     = 1'b1;
        cfg_tiles = n;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic serve_tile(input bit early);
        wait_out(0, "wait_disp_start");
        if (early) begin
            sa_done = 1'b1;
            @(negedge clk);
            sa_done = 1'b0;
        end
        disp_done = 1'b1;
        @(negedge clk);
        disp_done = 1'b0;
        if (early) begin
            @(negedge clk);
            chk("early_compute_skipped", 32'(col_start), 1);
        end else begin
            sa_done = 1'b1;
            @(negedge clk);
            sa_done = 1'b0;
        end
        wait_out(1, "wait_col_start");
        col_done = 1'b1;
        @(negedge clk);
        col_done = 1'b0;
    endtask

    int b_disp, b_clr, b_done, b_col, b_idx;

    initial begin
        nrst = 1'b0; start = 1'b0; cfg_tiles = '0;
        disp_done = 1'b0; sa_done = 1'b0; sa_err = 1'b0; col_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({busy, done, err, err_code, tile_idx, disp_start, col_start, tile_clr}), 0);
        nrst = 1'b1;
        @(negedge clk);

        // Three-tile job with ideal handshakes
        b_disp = n_disp; b_clr = n_clr; b_done = n_done; b_idx = idx_log.size();
        do_start(3);
        chk("first_disp_start", 32'(disp_start), 1);
        chk("first_busy", 32'(busy), 1);
        chk("first_tile_idx", 32'(tile_idx), 0);
        for (int t = 0; t < 3; t++) serve_tile(1'b0);
        wait_out(2, "wait_done_3");
        chk("done_busy_low", 32'(busy), 0);
        @(negedge clk);
        chk("j3_done_pulses", n_done - b_done, 1);
        chk("j3_disp_pulses", n_disp - b_disp, 3);
        chk("j3_clr_pulses", n_clr - b_clr, 3);
        for (int t = 0; t < 3; t++) chk("j3_tile_idx", 32'(idx_log[b_idx + t]), t);
        chk("j3_err", 32'({err, err_code}), 0);

        // Zero-tile request
        b_disp = n_disp;
        do_start(0);
        chk("zero_err", 32'(err), 1);
        chk("zero_code", 32'(err_code), 2);
        @(negedge clk);
        chk("zero_busy_low", 32'(busy), 0);
        chk("zero_tile_clr", 32'(tile_clr), 1);
        repeat (3) @(negedge clk);
        chk("zero_err_sticky", 32'({err, err_code}), 32'h6);
        chk("zero_no_disp", n_disp - b_disp, 0);

        // Array error with simultaneous sa_done on tile 1 of 2
        b_done = n_done;
        do_start(2);
        chk("start_clears_err", 32'({err, err_code}), 0);
        serve_tile(1'b0);
        wait_out(0, "wait_disp_t1");
        b_col = n_col;
        disp_done = 1'b1;
        @(negedge clk);
        disp_done = 1'b0;
        sa_err = 1'b1; sa_done = 1'b1;
        @(negedge clk);
        sa_err = 1'b0; sa_done = 1'b0;
        chk("saerr_err", 32'(err), 1);
        chk("saerr_code", 32'(err_code), 1);
        chk("saerr_no_col", 32'(col_start), 0);
        @(negedge clk);
        chk("saerr_busy_low", 32'(busy), 0);
        chk("saerr_tile_clr", 32'(tile_clr), 1);
        @(negedge clk);
        chk("saerr_col_cycles", n_col - b_col, 0);
        chk("saerr_no_done", n_done - b_done, 0);

        // sa_done before disp_done
        b_done = n_done;
        do_start(1);
        chk("early_err_cleared", 32'({err, err_code}), 0);
        serve_tile(1'b1);
        wait_out(2, "wait_done_early");
        @(negedge clk);
        chk("early_done_pulses", n_done - b_done, 1);
        chk("early_err", 32'(err), 0);

        // Dispatcher never finishes
        do_start(1);
`ifdef SYS_SCHED_WDOG_EN
        repeat (15) @(negedge clk);
        chk("wdog_not_yet", 32'({busy, err}), 32'h2);
        @(negedge clk);
        chk("wdog_err", 32'(err), 1);
        chk("wdog_code", 32'(err_code), 3);
        @(negedge clk);
        chk("wdog_busy_low", 32'(busy), 0);
`else
        repeat (40) @(negedge clk);
        chk("nowdog_busy", 32'(busy), 1);
        chk("nowdog_err", 32'({err, err_code}), 0);
`endif
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Reset during COLLECT of tile 2, then a clean one-tile job
        do_start(3);
        serve_tile(1'b0);
        serve_tile(1'b0);
        wait_out(0, "wait_disp_t2");
        disp_done = 1'b1;
        @(negedge clk);
        disp_done = 1'b0;
        sa_done = 1'b1;
        @(negedge clk);
        sa_done = 1'b0;
        wait_out(1, "wait_col_t2");
        chk("pre_rst_idx", 32'(tile_idx), 2);
        b_done = n_done; b_clr = n_clr;
        nrst = 1'b0;
        #1;
        chk("midjob_reset_outputs", 32'({busy, done, err, err_code, tile_idx, disp_start, col_start, tile_clr}), 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("rst_no_done", n_done - b_done, 0);
        chk("rst_no_clr", n_clr - b_clr, 0);
        b_done = n_done;
        do_start(1);
        serve_tile(1'b0);
        wait_out(2, "wait_done_after_rst");
        @(negedge clk);
        chk("after_rst_done", n_done - b_done, 1);
        chk("after_rst_err", 32'(err), 0);

        chk("no_back_to_back_pulses", n_consec, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
